// File: rtl/minv_bin_euclid_ctrl.sv
// Binary extended-Euclid engine: result = a^-1 mod p for odd p.
// Each RUN cycle performs one halving or one subtraction on (u, x1) or
// (v, x2). On success it writes the minv flag register, telling the
// consumer whether the inverse came out of x1 (flag 0) or x2 (flag 1).
module minv_bin_euclid_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] p_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             minv_flag_in,
  output logic             minv_flag_we
);

  typedef enum logic [1:0] {IDLE, RUN, FIN, ERR} state_t;

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] THREE = WIDTH'(3);

  state_t           state, state_n;
  logic [WIDTH-1:0] u, v, x1, x2, p_q;
  logic [WIDTH-1:0] u_n, v_n, x1_n, x2_n, p_n;
  logic [WIDTH-1:0] result_n;
  logic             busy_n, done_n, err_n, flag_n, we_n;
  logic             bad_operands;

  // x/2 mod p: an odd x gets p added first. The sum is formed one bit wider
  // so that p close to 2^WIDTH cannot overflow before the shift.
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return WIDTH'(s >> 1);
  endfunction

  // (x - y) mod p for x, y already in [0, p-1]. Wrap-around in WIDTH bits
  // gives the correct value because the true result fits in WIDTH bits.
  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [WIDTH-1:0] m);
    return (x >= y) ? (x - y) : (x - y + m);
  endfunction

  assign bad_operands = (a_in == '0) || !p_in[0] || (p_in < THREE) || (a_in >= p_in);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state, working-register and registered-output decisions.
  always_comb begin
    state_n  = state;
    u_n      = u;
    v_n      = v;
    x1_n     = x1;
    x2_n     = x2;
    p_n      = p_q;
    busy_n   = busy;
    done_n   = 1'b0;
    err_n    = 1'b0;
    we_n     = 1'b0;
    flag_n   = minv_flag_in;
    result_n = result;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          p_n    = p_in;
          busy_n = 1'b1;
          if (bad_operands) begin
            state_n  = ERR;
            done_n   = 1'b1;
            err_n    = 1'b1;
            result_n = '0;
          end else begin
            u_n     = a_in;
            v_n     = p_in;
            x1_n    = ONE;
            x2_n    = '0;
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (u == '0 || v == '0) begin
          state_n  = ERR;
          done_n   = 1'b1;
          err_n    = 1'b1;
          result_n = '0;
        end else if (u == ONE || v == ONE) begin
          state_n = FIN;
          done_n  = 1'b1;
          we_n    = 1'b1;
          if (u == ONE) begin
            flag_n   = 1'b0;
            result_n = x1;
          end else begin
            flag_n   = 1'b1;
            result_n = x2;
          end
        end else if (!u[0]) begin
          u_n  = u >> 1;
          x1_n = half_mod(x1, p_q);
        end else if (!v[0]) begin
          v_n  = v >> 1;
          x2_n = half_mod(x2, p_q);
        end else if (u >= v) begin
          u_n  = u - v;
          x1_n = sub_mod(x1, x2, p_q);
        end else begin
          v_n  = v - u;
          x2_n = sub_mod(x2, x1, p_q);
        end
      end
      FIN, ERR: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Working registers and registered outputs; reset clears everything so no
  // stray write strobe can follow an aborted operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u            <= '0;
      v            <= '0;
      x1           <= '0;
      x2           <= '0;
      p_q          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      result       <= '0;
      minv_flag_in <= 1'b0;
      minv_flag_we <= 1'b0;
    end else begin
      u            <= u_n;
      v            <= v_n;
      x1           <= x1_n;
      x2           <= x2_n;
      p_q          <= p_n;
      busy         <= busy_n;
      done         <= done_n;
      err          <= err_n;
      result       <= result_n;
      minv_flag_in <= flag_n;
      minv_flag_we <= we_n;
    end
  end

endmodule

// File: tb/tb_minv_bin_euclid_ctrl.sv
// Directed bench for minv_bin_euclid_ctrl: an 8-bit instance for the
// hand-worked vectors and a 16-bit instance for a random inverse sweep.
module tb_minv_bin_euclid_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, p8 = '0;
  logic       busy8, done8, err8, flag8, we8;
  logic [7:0] res8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, p16 = '0;
  logic        busy16, done16, err16, flag16, we16;
  logic [15:0] res16;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] obs_res, obs_err, obs_we, obs_flag, obs_busy;
  logic [31:0] obs_busy_after, obs_done_after;
  int          lat;
  logic [31:0] tmo;
  bit          carry_watch = 1'b0;

  logic [15:0] ra, rp;
  int          mflag, mruns, max_lat;
  longint      prod;

  minv_bin_euclid_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .p_in(p8),
    .busy(busy8), .done(done8), .err(err8), .result(res8),
    .minv_flag_in(flag8), .minv_flag_we(we8)
  );

  minv_bin_euclid_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a_in(a16), .p_in(p16),
    .busy(busy16), .done(done16), .err(err16), .result(res16),
    .minv_flag_in(flag16), .minv_flag_we(we16)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Issue one start on the chosen instance and wait for done. With spam set,
  // random start pulses and operand changes are thrown at the 16-bit
  // instance while it is busy, and start is held through the done cycle.
  task automatic applyStimulus(input bit sel16, input logic [15:0] a,
                               input logic [15:0] p, input bit spam);
    int k;
    @(negedge clk);
    if (sel16) begin a16 = a; p16 = p; start16 = 1'b1; end
    else begin a8 = a[7:0]; p8 = p[7:0]; start8 = 1'b1; end
    @(negedge clk);
    start8  = 1'b0;
    start16 = 1'b0;
    k = 1;
    while (!(sel16 ? done16 : done8) && k < 300) begin
      if (spam) begin
        start16 = 1'($urandom_range(1, 0));
        a16     = 16'($urandom);
        p16     = 16'($urandom);
      end
      @(negedge clk);
      k++;
    end
    tmo      = 32'(!(sel16 ? done16 : done8));
    lat      = k - 1;
    obs_res  = sel16 ? 32'(res16) : 32'(res8);
    obs_err  = 32'(sel16 ? err16 : err8);
    obs_we   = 32'(sel16 ? we16 : we8);
    obs_flag = 32'(sel16 ? flag16 : flag8);
    obs_busy = 32'(sel16 ? busy16 : busy8);
    start16  = spam;
    @(negedge clk);
    obs_busy_after = 32'(sel16 ? busy16 : busy8);
    obs_done_after = 32'(sel16 ? done16 : done8);
    start16 = 1'b0;
  endtask

  task automatic checkOp(input string tag, input int exp_lat, input bit exp_err,
                         input logic [15:0] exp_res, input bit chk_flag,
                         input bit exp_flag);
    checkOutput({tag, "_timeout"}, tmo, 32'd0);
    checkOutput({tag, "_run_cycles"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_err"}, obs_err, 32'(exp_err));
    checkOutput({tag, "_flag_we"}, obs_we, 32'(!exp_err));
    checkOutput({tag, "_result"}, obs_res, 32'(exp_res));
    if (chk_flag) checkOutput({tag, "_flag_in"}, obs_flag, 32'(exp_flag));
    checkOutput({tag, "_busy_in_done"}, obs_busy, 32'd1);
    checkOutput({tag, "_busy_after"}, obs_busy_after, 32'd0);
    checkOutput({tag, "_done_after"}, obs_done_after, 32'd0);
  endtask

  // Plain integer rendition of the algorithm: which register ends at 1 and
  // how many RUN cycles (including the detecting one) that takes.
  function automatic void ref_model(input longint a, input longint p,
                                    output int flag, output int runs);
    longint u, v, x1, x2;
    u = a; v = p; x1 = 1; x2 = 0;
    flag = -1;
    runs = 0;
    for (int i = 0; i < 400; i++) begin
      runs++;
      if (u == 0 || v == 0) return;
      if (u == 1) begin flag = 0; return; end
      if (v == 1) begin flag = 1; return; end
      if (u % 2 == 0) begin
        u = u / 2;
        x1 = (x1 % 2 == 0) ? x1 / 2 : (x1 + p) / 2;
      end else if (v % 2 == 0) begin
        v = v / 2;
        x2 = (x2 % 2 == 0) ? x2 / 2 : (x2 + p) / 2;
      end else if (u >= v) begin
        u = u - v;
        x1 = (x1 - x2 + p) % p;
      end else begin
        v = v - u;
        x2 = (x2 - x1 + p) % p;
      end
    end
  endfunction

  function automatic longint gcd(input longint a, input longint b);
    longint t;
    for (int i = 0; i < 100 && b != 0; i++) begin
      t = a % b; a = b; b = t;
    end
    return a;
  endfunction

  // During the a=2, p=255 run the x registers must stay below p even though
  // x1 + p needs a ninth bit.
  always @(negedge clk) begin
    if (carry_watch && busy8 && !done8)
      checkOutput("carry_x_range", 32'(dut8.x1 < 8'd255 && dut8.x2 < 8'd255), 32'd1);
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy8), 32'd0);
    checkOutput("rst_done", 32'(done8), 32'd0);
    checkOutput("rst_err", 32'(err8), 32'd0);
    checkOutput("rst_result", 32'(res8), 32'd0);
    checkOutput("rst_flag_in", 32'(flag8), 32'd0);
    checkOutput("rst_flag_we", 32'(we8), 32'd0);
    checkOutput("rst_busy16", 32'(busy16), 32'd0);
    rst_n = 1'b1;

    $display("[TB] basic inverse 3^-1 mod 7");
    applyStimulus(1'b0, 16'd3, 16'd7, 1'b0);
    checkOp("basic", 4, 1'b0, 16'd5, 1'b1, 1'b1);

    $display("[TB] asynchronous reset during RUN cycle 2");
    @(negedge clk);
    a8 = 8'd3; p8 = 8'd7; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("mid_busy_before", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_busy", 32'(busy8), 32'd0);
    checkOutput("mid_done", 32'(done8), 32'd0);
    checkOutput("mid_err", 32'(err8), 32'd0);
    checkOutput("mid_result", 32'(res8), 32'd0);
    checkOutput("mid_flag_in", 32'(flag8), 32'd0);
    checkOutput("mid_flag_we", 32'(we8), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("mid_flag_we_held", 32'(we8), 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'd3, 16'd7, 1'b0);
    checkOp("rerun", 4, 1'b0, 16'd5, 1'b1, 1'b1);

    $display("[TB] immediate u==1 and carry path");
    applyStimulus(1'b0, 16'd1, 16'd7, 1'b0);
    checkOp("immediate", 1, 1'b0, 16'd1, 1'b1, 1'b0);
    carry_watch = 1'b1;
    applyStimulus(1'b0, 16'd2, 16'd255, 1'b0);
    carry_watch = 1'b0;
    checkOp("carry", 2, 1'b0, 16'd128, 1'b1, 1'b0);

    $display("[TB] error cases");
    applyStimulus(1'b0, 16'd6, 16'd9, 1'b0);
    checkOp("gcd3", 5, 1'b1, 16'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd0, 16'd7, 1'b0);
    checkOp("a_zero", 0, 1'b1, 16'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd1, 16'd3, 1'b0);
    checkOp("p_three", 1, 1'b0, 16'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'd3, 16'd8, 1'b0);
    checkOp("p_even", 0, 1'b1, 16'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd9, 16'd7, 1'b0);
    checkOp("a_ge_p", 0, 1'b1, 16'd0, 1'b0, 1'b0);

    $display("[TB] random sweep, 16-bit instance");
    max_lat = 0;
    for (int n = 0; n < 1000; n++) begin
      rp = 16'($urandom_range(65535, 3)) | 16'd1;
      ra = 16'($urandom_range(32'(rp) - 1, 1));
      for (int t = 0; t < 100 && gcd(longint'(ra), longint'(rp)) != 1; t++)
        ra = 16'($urandom_range(32'(rp) - 1, 1));
      if (gcd(longint'(ra), longint'(rp)) != 1) ra = 16'd1;
      ref_model(longint'(ra), longint'(rp), mflag, mruns);
      applyStimulus(1'b1, ra, rp, 1'b1);
      if (lat > max_lat) max_lat = lat;
      prod = (longint'(ra) * longint'(obs_res[15:0])) % longint'(rp);
      checkOutput("rnd_timeout", tmo, 32'd0);
      checkOutput("rnd_inverse", 32'(prod), 32'd1);
      checkOutput("rnd_flag_in", obs_flag, 32'(mflag));
      checkOutput("rnd_run_cycles", 32'(lat), 32'(mruns));
      checkOutput("rnd_err", obs_err, 32'd0);
      checkOutput("rnd_flag_we", obs_we, 32'd1);
      checkOutput("rnd_start_at_done_ignored", obs_busy_after, 32'd0);
    end
    $display("[TB] sweep: longest RUN sequence %0d cycles", max_lat);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
